// File: rtl/motoro_pkg.sv
// Shared types and constants for the gate-drive guard blocks.
package motoro_pkg;

   typedef enum logic [1:0] {
      OFF_WAIT = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2,
      LOW      = 2'd3
   } phase_state_e;

   localparam int unsigned DT_RST_DEFAULT = 50;
   localparam int unsigned FAULT_CNT_W    = 16;

endpackage

// File: rtl/gate_guard_phase.sv
// One half-bridge leg: dead-time enforcing FSM with registered high/low gate drives.
module gate_guard_phase
   import motoro_pkg::*;
#(
   parameter int unsigned DT_W   = 8,
   parameter int unsigned DT_RST = DT_RST_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            h_req_i,
   input  logic            l_req_i,
   input  logic            hold_i,
   input  logic [DT_W-1:0] dt_cycles_i,
   output logic            h_drv_o,
   output logic            l_drv_o
);

   localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

   phase_state_e    state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic            h_q, h_d;
   logic            l_q, l_d;
   logic [DT_W-1:0] load_val_c;
   logic            illegal_c;

   // A zero dead time would let both switches toggle on the same edge; clamp to one cycle.
   assign load_val_c = (dt_cycles_i == '0) ? CNT_ONE : dt_cycles_i;
   assign illegal_c  = h_req_i & l_req_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OFF_WAIT;
         cnt_q   <= DT_W'(DT_RST);
         h_q     <= 1'b0;
         l_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         l_q     <= l_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (hold_i || illegal_c) begin
         state_d = OFF_WAIT;
         cnt_d   = load_val_c;
      end else begin
         case (state_q)
            OFF_WAIT: begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q <= CNT_ONE) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
            IDLE: begin
               if (h_req_i) begin
                  state_d = HIGH;
               end else if (l_req_i) begin
                  state_d = LOW;
               end
            end
            HIGH: begin
               if (!h_req_i || l_req_i) begin
                  state_d = OFF_WAIT;
                  cnt_d   = load_val_c;
               end
            end
            LOW: begin
               if (!l_req_i || h_req_i) begin
                  state_d = OFF_WAIT;
                  cnt_d   = load_val_c;
               end
            end
            default: begin
               state_d = OFF_WAIT;
               cnt_d   = load_val_c;
            end
         endcase
      end
   end

   // Drives are flopped from the next state so they track the state register exactly.
   always_comb begin
      h_d = (state_d == HIGH);
      l_d = (state_d == LOW);
   end

   assign h_drv_o = h_q;
   assign l_drv_o = l_q;

endmodule

// File: rtl/gate_guard_np.sv
// Multi-phase gate-drive guard: per-phase dead-time FSMs plus shoot-through fault latch.
// Optional fault event counter port faultCntO enabled by defining GATE_GUARD_FAULT_CNT_EN.
module gate_guard_np
   import motoro_pkg::*;
#(
   parameter int unsigned PHASES = 3,
   parameter int unsigned DT_W   = 8,
   parameter int unsigned DT_RST = DT_RST_DEFAULT
) (
   input  logic              clk50mhzI,
   input  logic              nResetI,
   input  logic              enI,
   input  logic [PHASES-1:0] hReqI,
   input  logic [PHASES-1:0] lReqI,
   input  logic [DT_W-1:0]   dtCyclesI,
   input  logic              faultClrI,
   output logic [PHASES-1:0] hPo,
   output logic [PHASES-1:0] lNo,
   output logic              faultO,
   output logic [PHASES-1:0] faultPhaseO
`ifdef GATE_GUARD_FAULT_CNT_EN
   ,
   output logic [FAULT_CNT_W-1:0] faultCntO
`endif
);

   logic              fault_q, fault_d;
   logic [PHASES-1:0] fault_phase_q, fault_phase_d;
   logic [PHASES-1:0] illegal_c;
   logic              new_fault_c;
   logic              hold_c;

   assign illegal_c   = hReqI & lReqI;
   assign new_fault_c = |illegal_c;
   assign hold_c      = fault_q | ~enI;

   // A fresh illegal request always beats a clear in the same cycle.
   always_comb begin
      fault_d       = fault_q;
      fault_phase_d = fault_phase_q;
      if (new_fault_c) begin
         fault_d       = 1'b1;
         fault_phase_d = fault_phase_q | illegal_c;
      end else if (faultClrI) begin
         fault_d       = 1'b0;
         fault_phase_d = '0;
      end
   end

   always_ff @(posedge clk50mhzI or negedge nResetI) begin
      if (!nResetI) begin
         fault_q       <= 1'b0;
         fault_phase_q <= '0;
      end else begin
         fault_q       <= fault_d;
         fault_phase_q <= fault_phase_d;
      end
   end

   assign faultO      = fault_q;
   assign faultPhaseO = fault_phase_q;

   for (genvar g = 0; g < PHASES; g++) begin : g_phase
      gate_guard_phase #(
         .DT_W   (DT_W),
         .DT_RST (DT_RST)
      ) u_phase (
         .clk         (clk50mhzI),
         .rst_n       (nResetI),
         .h_req_i     (hReqI[g]),
         .l_req_i     (lReqI[g]),
         .hold_i      (hold_c),
         .dt_cycles_i (dtCyclesI),
         .h_drv_o     (hPo[g]),
         .l_drv_o     (lNo[g])
      );
   end

`ifdef GATE_GUARD_FAULT_CNT_EN
   logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

   // Counts visible 0->1 transitions of faultO, saturating.
   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (fault_d && !fault_q && (fault_cnt_q != '1)) begin
         fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk50mhzI or negedge nResetI) begin
      if (!nResetI) begin
         fault_cnt_q <= '0;
      end else begin
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign faultCntO = fault_cnt_q;
`endif

endmodule
